// File: rtl/enc_disp_pkg.sv
// Shared definitions for the encoder history display: active-low seven-segment
// glyphs (bit0 = segment a), the history entry record and the hex decoder.
package enc_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       vld;
    logic [2:0] code;
  } hist_entry_t;

  localparam hist_entry_t HIST_EMPTY = '{vld: 1'b0, code: 3'd0};

  function automatic logic [6:0] hex2seg(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/enc_hist_disp_scan_timer.sv
// Scan timing for the multiplexed display: a prescaler that strobes every
// SCAN_DIV cycles and a digit index that steps 0..DIGITS-1 on each strobe.
module scan_timer #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [$clog2(DIGITS)-1:0] digit_o,
  output logic                      adv_o
);

  localparam int DW = $clog2(DIGITS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] digit_q, digit_d;

  // With SCAN_DIV = 1 the prescaler sits at 0, which is also its terminal count.
  assign adv_o   = (presc_q == PRESC_LAST);
  assign digit_o = digit_q;

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    if (adv_o) begin
      presc_d = '0;
      digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      digit_q <= '0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/enc_hist_disp.sv
// Scanned seven-segment history display behind the 8-to-3 priority encoder.
// Build option ENC_DISP_CNT_EN: top digit shows the event count in hex.
module enc_hist_disp
  import enc_disp_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_i,
  input  logic [2:0]        code_i,
  input  logic              valid_i,
  output logic [6:0]        seg_o,
  output logic [DIGITS-1:0] an_o,
  output logic [3:0]        hist_cnt_o
);

`ifdef ENC_DISP_CNT_EN
  localparam int HIST_DEPTH = DIGITS - 1;
`else
  localparam int HIST_DEPTH = DIGITS;
`endif
  localparam int DW = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] AN_FIRST = {{(DIGITS-1){1'b1}}, 1'b0};

  logic              held_q;
  logic [2:0]        last_code_q;
  hist_entry_t       hist_q [HIST_DEPTH];
  hist_entry_t       hist_d [HIST_DEPTH];
  logic [3:0]        cnt_q, cnt_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              scan_adv_q;
  logic [DW-1:0]     digit;
  logic              scan_adv;
  logic              event_w;
  hist_entry_t       entry_sel;

  scan_timer #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) u_scan_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .digit_o(digit),
    .adv_o  (scan_adv)
  );

  // A held key only counts again once its code changes or all keys are released.
  assign event_w = ena_i && valid_i && (!held_q || (code_i != last_code_q));

  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (event_w) begin
      hist_d[0] = '{vld: 1'b1, code: code_i};
      for (int k = 1; k < HIST_DEPTH; k++) begin
        hist_d[k] = hist_q[k-1];
      end
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    entry_sel = HIST_EMPTY;
    for (int k = 0; k < HIST_DEPTH; k++) begin
      if (digit == DW'(k)) entry_sel = hist_q[k];
    end
    seg_d = entry_sel.vld ? hex2seg({1'b0, entry_sel.code}) : SEG_BLANK;
`ifdef ENC_DISP_CNT_EN
    if (digit == DW'(DIGITS - 1)) seg_d = hex2seg(cnt_q);
`endif
  end

  // Anode register follows the digit index one cycle late: it loads digit 0
  // after reset, then rotates on the delayed advance strobe, in step with seg_q.
  always_comb begin
    an_d = an_q;
    if (&an_q) begin
      an_d = AN_FIRST;
    end else if (scan_adv_q) begin
      an_d = {an_q[DIGITS-2:0], an_q[DIGITS-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_q      <= 1'b0;
      last_code_q <= 3'd0;
      cnt_q       <= 4'd0;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
      scan_adv_q  <= 1'b0;
      // NOTE: the history is a handful of flops whose valid bits must read as
      // empty after reset, so it is reset like any other register, not as a RAM.
      for (int k = 0; k < HIST_DEPTH; k++) begin
        hist_q[k] <= HIST_EMPTY;
      end
    end else begin
      held_q      <= ena_i && valid_i;
      last_code_q <= code_i;
      cnt_q       <= cnt_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      scan_adv_q  <= scan_adv;
      hist_q      <= hist_d;
    end
  end

  assign seg_o      = seg_q;
  assign an_o       = an_q;
  assign hist_cnt_o = cnt_q;

endmodule

// File: doc/enc_hist_disp.md
# enc_hist_disp

Time-multiplexed seven-segment display stage sitting directly downstream of the 8-to-3 priority encoder. Samples the encoder's 3-bit code and valid flag each clock, keeps a shift history of the last `DIGITS` distinct key events, and scans them onto a common-anode multi-digit display, one digit per scan slot. Replaces the single static combinational 7-segment output with a registered, scanned, history-keeping display.

## Interface
- `DIGITS`, default 4: number of display digits and history depth (2..8).
- `SCAN_DIV`, default 1000: clock cycles per digit scan slot (≥1).
- `clk`  in  1  system clock, all logic rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ena_i`  in  1  encoder enable; events ignored when low.
- `code_i`  in  3  encoder output code.
- `valid_i`  in  1  encoder "any input active" flag.
- `seg_o`  out  7  segments a..g (bit0 = a), active-low.
- `an_o`  out  DIGITS  digit enables, active-low, one-hot-low.
- `hist_cnt_o`  out  4  total accepted events, mod 16.

## Operation
- Event rule: event accepted in cycle where `ena_i && valid_i && (!held || code_i != last_code)`. `held`/`last_code` updated every cycle: `held <= ena_i && valid_i`, `last_code <= code_i`. Releasing all keys (valid_i low) clears `held`, so re-pressing same key is a new event.
- History: `DIGITS` entries, each {valid, 3-bit code}. On event: entry0 ← {1, code_i}, entry k ← entry k-1, oldest dropped. Invalid entries display blank (all segments off).
- `hist_cnt_o` increments on each event, wraps 15 → 0.
- Scan: prescaler counts 0..SCAN_DIV-1; at terminal count, digit index advances, wrapping DIGITS-1 → 0. Digit 0 (rightmost) = newest entry.
- Output: `an_o` drives low only bit = digit index; `seg_o` = hex pattern of that digit's entry (0–7 used), or 7'h7F if entry invalid.
- Reset: prescaler 0, digit index 0, all entries invalid, `held` 0, `hist_cnt_o` 0, `seg_o` 7'h7F, `an_o` all ones.

## Timing
- Event in cycle N → entry0 updated end of N → visible on `seg_o` from cycle N+2 if digit 0 currently selected (one register stage on outputs).
- Digit index change at end of cycle with prescaler = SCAN_DIV-1; `an_o`/`seg_o` change together one cycle later; never a cycle with two digits enabled.
- SCAN_DIV = 1: digit advances every cycle; must still work.
- Event and scan advance in same cycle: both take effect; no event lost.
- Event every cycle (code changing each cycle): one push per cycle.
- `rst_n` low mid-scan: outputs return to reset values the following cycle regardless of state.

## Configuration
- `ENC_DISP_CNT_EN` defined: digit DIGITS-1 shows `hist_cnt_o` as hex 0–F (always valid, never blank); history shown on digits 0..DIGITS-2 only, depth DIGITS-1.
- Undefined: all DIGITS digits show history; `hist_cnt_o` port still present.

## Structure
- Package `enc_disp_pkg`: active-low hex segment constants 0–F, `SEG_BLANK` = 7'h7F, `hex2seg` function, history entry struct typedef.
- Sub-module `scan_timer`: prescaler plus digit index counter, parameters `DIGITS`, `SCAN_DIV`, outputs digit index and advance strobe.
- Top holds event detection, history shift register, count, output mux/registers.

## Test plan
(DIGITS=4, SCAN_DIV=4 unless stated)
- Reset then 40 idle cycles → `an_o` cycles 1110,1101,1011,0111 every 4 cycles; `seg_o` = 7'h7F throughout; `hist_cnt_o` = 0.
- Hold code 5 valid for 20 cycles → exactly one event; digit 0 shows 7'h12; `hist_cnt_o` = 1.
- Sequence 3, release, 3, 6, 1, 7 → history newest→oldest 7,1,6,3; `hist_cnt_o` = 5; digit 0 shows 7'h78.
- ena_i low while code 2 valid → no event, display unchanged; raise ena_i → event accepted next cycle.
- SCAN_DIV=1 and codes 0..7 one per cycle → eight events, `hist_cnt_o` = 8, digits show 7,6,5,4; one-hot-low `an_o` every cycle.
- `ENC_DISP_CNT_EN` with 17 events → digit 3 shows 7'h79 (count 1); assert rst_n low mid-scan → `seg_o` 7'h7F, `an_o` 1111 next cycle.
